tx_dispatcher: RTL and testbench

- Host-to-peripheral counterpart of the RX arbitration path: takes the 32-bit word stream read from the FT601 and routes packets into one of 8 per-peripheral TX FIFOs.
- Each packet is one header word carrying the peripheral address and payload length, followed by that many payload words.
- Applies per-FIFO backpressure to the FT601 read side.
- Drains packets addressed to disabled peripherals and counts them.

---
 rtl/ui_pkg.sv | 33 +++
 rtl/tx_dispatcher_if.sv | 29 ++
 rtl/tx_hdr_decode.sv | 28 ++
 rtl/tx_dispatcher.sv | 121 ++++++++++++
 tb/tb_tx_dispatcher.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ui_pkg.sv
// -----------------------------------------------------------------------------
// ui_pkg
// Shared constants and types for the host-to-peripheral TX dispatch path.
//   NUM_PERIPH / ADDR_WIDTH  : peripheral FIFO count and address width
//   DATA_WIDTH / LEN_WIDTH   : stream word width and header length-field width
//   HDR_*                    : header field bit positions
//   tx_disp_state_t          : dispatcher FSM state encoding
// -----------------------------------------------------------------------------
package ui_pkg;

   localparam int NUM_PERIPH = 8;
   localparam int ADDR_WIDTH = $clog2(NUM_PERIPH);
   localparam int DATA_WIDTH = 32;
   localparam int LEN_WIDTH  = 8;

   // Peripheral address sits in the top bits, payload length in the bottom bits.
   localparam int HDR_ADDR_MSB = DATA_WIDTH - 1;
   localparam int HDR_ADDR_LSB = DATA_WIDTH - ADDR_WIDTH;
   localparam int HDR_LEN_MSB  = LEN_WIDTH - 1;
   localparam int HDR_LEN_LSB  = 0;

   typedef enum logic [1:0] {
      TX_IDLE    = 2'd0,
      TX_FORWARD = 2'd1,
      TX_DISCARD = 2'd2
   } tx_disp_state_t;

   function automatic logic [NUM_PERIPH-1:0] periph_onehot(input logic [ADDR_WIDTH-1:0] addr);
      periph_onehot       = '0;
      periph_onehot[addr] = 1'b1;
   endfunction

endpackage

// File: rtl/tx_dispatcher_if.sv
// -----------------------------------------------------------------------------
// tx_dispatcher_if
// Stream input and TX FIFO write bus of the dispatcher.
//   in_data / in_valid / in_ready : FT601 read-side word stream
//   tx_fifo_almost_full           : per-FIFO "at most one free entry" flags
//   tx_fifo_wr_en / tx_fifo_din   : one-hot write strobe and shared write data
// master = host/stream side, slave = dispatcher.
// -----------------------------------------------------------------------------
interface tx_dispatcher_if;
   import ui_pkg::*;

   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [NUM_PERIPH-1:0] tx_fifo_almost_full;
   logic [NUM_PERIPH-1:0] tx_fifo_wr_en;
   logic [DATA_WIDTH-1:0] tx_fifo_din;

   modport master (
      output in_data, in_valid, tx_fifo_almost_full,
      input  in_ready, tx_fifo_wr_en, tx_fifo_din
   );

   modport slave (
      input  in_data, in_valid, tx_fifo_almost_full,
      output in_ready, tx_fifo_wr_en, tx_fifo_din
   );

endinterface

// File: rtl/tx_hdr_decode.sv
// -----------------------------------------------------------------------------
// tx_hdr_decode
// Combinational header field extraction plus peripheral enable lookup.
//   hdr           in  : candidate header word
//   periph_enable in  : per-peripheral enable mask
//   hdr_addr      out : peripheral address field
//   hdr_len       out : payload length field
//   hdr_enabled   out : enable bit of the addressed peripheral
// -----------------------------------------------------------------------------
module tx_hdr_decode
   import ui_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] hdr,
   input  logic [NUM_PERIPH-1:0] periph_enable,
   output logic [ADDR_WIDTH-1:0] hdr_addr,
   output logic [LEN_WIDTH-1:0]  hdr_len,
   output logic                  hdr_enabled
);

   // Bits between the address and length fields carry no meaning.
   logic unused_hdr_bits;

   assign hdr_addr        = hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
   assign hdr_len         = hdr[HDR_LEN_MSB:HDR_LEN_LSB];
   assign hdr_enabled     = periph_enable[hdr_addr];
   assign unused_hdr_bits = ^hdr[HDR_ADDR_LSB-1:HDR_LEN_MSB+1];

endmodule

// File: rtl/tx_dispatcher.sv
// -----------------------------------------------------------------------------
// tx_dispatcher
// Routes header+payload packets from the FT601 word stream into one of
// NUM_PERIPH TX FIFOs, backpressuring on the addressed FIFO's almost_full,
// and drains/counts packets aimed at disabled peripherals.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : stream in + FIFO write bus (wr_en/din registered)
//   periph_enable : enable mask, sampled at header accept only
//   busy          : high whenever not IDLE
//   drop_count    : saturating count of discarded packets
// -----------------------------------------------------------------------------
module tx_dispatcher
   import ui_pkg::*;
#(
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   tx_dispatcher_if.slave            bus,
   input  logic [NUM_PERIPH-1:0]     periph_enable,
   output logic                      busy,
   output logic [DROP_CNT_WIDTH-1:0] drop_count
);

   localparam logic [1:0] IDLE    = TX_IDLE;
   localparam logic [1:0] FORWARD = TX_FORWARD;
   localparam logic [1:0] DISCARD = TX_DISCARD;

   logic [1:0]                state_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [LEN_WIDTH-1:0]      remaining_q;
   logic [NUM_PERIPH-1:0]     wr_en_q;
   logic [DATA_WIDTH-1:0]     din_q;
   logic [DROP_CNT_WIDTH-1:0] drop_q;

   logic [ADDR_WIDTH-1:0]     hdr_addr;
   logic [LEN_WIDTH-1:0]      hdr_len;
   logic                      hdr_enabled;
   logic                      in_ready;
   logic                      accept;
   logic                      last_word;

   tx_hdr_decode u_hdr_decode (
      .hdr           (bus.in_data),
      .periph_enable (periph_enable),
      .hdr_addr      (hdr_addr),
      .hdr_len       (hdr_len),
      .hdr_enabled   (hdr_enabled)
   );

   // Only a forwarded payload can be stalled; headers and drained words always flow.
   always_comb begin
      // NOTE: assign a default before any condition so the block never infers a latch.
      in_ready = 1'b1;
      if (state_q == FORWARD) begin
         in_ready = ~bus.tx_fifo_almost_full[addr_q];
      end
   end

   assign accept    = bus.in_valid & in_ready;
   assign last_word = (remaining_q == LEN_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         wr_en_q     <= '0;
         din_q       <= '0;
         drop_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         wr_en_q <= '0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q      <= hdr_addr;
                  remaining_q <= hdr_len;
                  // Zero-length headers are consumed silently.
                  if (hdr_len != '0) begin
                     if (hdr_enabled) begin
                        state_q <= FORWARD;
                     end else begin
                        state_q <= DISCARD;
                        if (~&drop_q) begin
                           drop_q <= drop_q + DROP_CNT_WIDTH'(1);
                        end
                     end
                  end
               end
            end
            FORWARD: begin
               if (accept) begin
                  wr_en_q     <= periph_onehot(addr_q);
                  din_q       <= bus.in_data;
                  remaining_q <= remaining_q - LEN_WIDTH'(1);
                  if (last_word) begin
                     state_q <= IDLE;
                  end
               end
            end
            DISCARD: begin
               if (accept) begin
                  remaining_q <= remaining_q - LEN_WIDTH'(1);
                  if (last_word) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.tx_fifo_wr_en = wr_en_q;
   assign bus.tx_fifo_din   = din_q;
   assign busy              = (state_q != IDLE);
   assign drop_count        = drop_q;

endmodule

// File: tb/tb_tx_dispatcher.sv
`timescale 1ns/1ps
module tb_tx_dispatcher;
   import ui_pkg::*;

   localparam int SMALL_W = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_PERIPH-1:0] periph_enable;
   logic                  busy, busy_s;
   logic [15:0]           drop_count;
   logic [SMALL_W-1:0]    drop_count_s;

   tx_dispatcher_if bus   ();
   tx_dispatcher_if bus_s ();

   // The narrow-counter instance sees exactly the same stream.
   assign bus_s.in_data             = bus.in_data;
   assign bus_s.in_valid            = bus.in_valid;
   assign bus_s.tx_fifo_almost_full = bus.tx_fifo_almost_full;

   tx_dispatcher dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .periph_enable (periph_enable),
      .busy          (busy),
      .drop_count    (drop_count)
   );

   tx_dispatcher #(.DROP_CNT_WIDTH(SMALL_W)) dut_s (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus_s),
      .periph_enable (periph_enable),
      .busy          (busy_s),
      .drop_count    (drop_count_s)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Packet-level reference model: position in the current packet, its
   // destination, and the expected effects of the word just accepted.
   int          pkt_left;
   logic [2:0]  pkt_addr;
   bit          pkt_fwd;
   int          drops, drops_s;
   bit          wr_pend;
   logic [2:0]  wr_addr;
   logic [31:0] din_exp;

   typedef struct {
      logic [31:0] data;
      bit          valid;
      logic [7:0]  af;
      bit          exp_ready;
      bit          exp_busy;
      logic [7:0]  exp_wr;
      logic [31:0] exp_din;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      pkt_left = 0;
      pkt_addr = '0;
      pkt_fwd  = 1'b0;
      drops    = 0;
      drops_s  = 0;
      wr_pend  = 1'b0;
      wr_addr  = '0;
      din_exp  = '0;
   endtask

   // One clock: drive, check combinational outputs, advance model, check registered outputs.
   task automatic cycle(input logic [31:0] d, input bit v, input logic [7:0] af,
                        output bit acc, output logic obs_ready, output logic obs_busy,
                        output logic [7:0] obs_wr, output logic [31:0] obs_din);
      bit exp_ready;
      bus.in_data             = d;
      bus.in_valid            = v;
      bus.tx_fifo_almost_full = af;
      #1;
      exp_ready = (pkt_left == 0) || !pkt_fwd || !af[pkt_addr];
      obs_ready = bus.in_ready;
      obs_busy  = busy;
      check("in_ready", bus.in_ready, exp_ready);
      check("in_ready_s", bus_s.in_ready, exp_ready);
      check("busy", busy, pkt_left != 0);
      acc     = v && exp_ready;
      wr_pend = 1'b0;
      if (acc) begin
         if (pkt_left == 0) begin
            if (d[7:0] != 8'd0) begin
               pkt_left = int'(d[7:0]);
               pkt_addr = d[31:29];
               pkt_fwd  = periph_enable[pkt_addr];
               if (!pkt_fwd) begin
                  if (drops < 65535) drops++;
                  if (drops_s < 3) drops_s++;
               end
            end
         end else begin
            if (pkt_fwd) begin
               wr_pend = 1'b1;
               wr_addr = pkt_addr;
               din_exp = d;
            end
            pkt_left--;
         end
      end
      @(posedge clk);
      #1;
      obs_wr  = bus.tx_fifo_wr_en;
      obs_din = bus.tx_fifo_din;
      check("wr_en", bus.tx_fifo_wr_en, wr_pend ? (8'b1 << wr_addr) : 8'h00);
      check("wr_en_s", bus_s.tx_fifo_wr_en, wr_pend ? (8'b1 << wr_addr) : 8'h00);
      check("din", bus.tx_fifo_din, din_exp);
      check("drop_count", drop_count, drops);
      check("drop_count_s", drop_count_s, drops_s);
   endtask

   task automatic apply_reset(input logic [31:0] d, input bit v);
      rst          = 1'b1;
      bus.in_data  = d;
      bus.in_valid = v;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      check("rst wr_en", bus.tx_fifo_wr_en, 8'h00);
      check("rst din", bus.tx_fifo_din, 32'h0);
      check("rst drop_count", drop_count, 16'h0);
      check("rst busy", busy, 1'b0);
   endtask

   initial begin
      bit          acc;
      logic        r, b;
      logic [7:0]  w;
      logic [31:0] dd;
      logic [7:0]  af;
      logic [7:0]  len;

      rst                     = 1'b1;
      bus.in_data             = '0;
      bus.in_valid            = 1'b0;
      bus.tx_fifo_almost_full = '0;
      periph_enable           = '1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("reset wr_en", bus.tx_fifo_wr_en, 8'h00);
      check("reset din", bus.tx_fifo_din, 32'h0);
      check("reset drop_count", drop_count, 16'h0);
      check("reset busy", busy, 1'b0);
      check("reset in_ready", bus.in_ready, 1'b1);
      rst = 1'b0;

      // Addr 3, N=4, payload A0..A3, no backpressure.
      tbl[0] = '{32'h6000_0004, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0000_0000};
      tbl[1] = '{32'h0000_00A0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h08, 32'h0000_00A0};
      tbl[2] = '{32'h0000_00A1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h08, 32'h0000_00A1};
      tbl[3] = '{32'h0000_00A2, 1'b1, 8'h00, 1'b1, 1'b1, 8'h08, 32'h0000_00A2};
      tbl[4] = '{32'h0000_00A3, 1'b1, 8'h00, 1'b1, 1'b1, 8'h08, 32'h0000_00A3};
      tbl[5] = '{32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0000_00A3};
      foreach (tbl[i]) begin
         cycle(tbl[i].data, tbl[i].valid, tbl[i].af, acc, r, b, w, dd);
         check($sformatf("tbl%0d ready", i), r, tbl[i].exp_ready);
         check($sformatf("tbl%0d busy", i), b, tbl[i].exp_busy);
         check($sformatf("tbl%0d wr_en", i), w, tbl[i].exp_wr);
         check($sformatf("tbl%0d din", i), dd, tbl[i].exp_din);
      end

      // Disabled peripheral 5: drained with in_ready high, counted once.
      periph_enable = 8'hDF;
      cycle(32'hA000_0003, 1'b1, 8'h00, acc, r, b, w, dd);
      for (int i = 0; i < 3; i++) begin
         cycle(32'hD0 + i, 1'b1, 8'hFF, acc, r, b, w, dd);
         check("discard ready", r, 1'b1);
         check("discard wr_en", w, 8'h00);
      end
      check("discard drop", drop_count, 16'd1);
      periph_enable = '1;

      // Addr 1, N=6, stall 5 cycles after the 2nd payload word.
      cycle(32'h2000_0006, 1'b1, 8'h00, acc, r, b, w, dd);
      cycle(32'hB0, 1'b1, 8'h00, acc, r, b, w, dd);
      cycle(32'hB1, 1'b1, 8'h00, acc, r, b, w, dd);
      for (int i = 0; i < 5; i++) begin
         cycle(32'hB2, 1'b1, 8'h02, acc, r, b, w, dd);
         check("stall ready", r, 1'b0);
         check("stall wr_en", w, 8'h00);
      end
      for (int i = 2; i < 6; i++) begin
         cycle(32'hB0 + i, 1'b1, 8'hFD, acc, r, b, w, dd);
         check("resume wr_en", w, 8'h02);
         check("resume din", dd, 32'hB0 + i);
      end

      // N=0 header (junk in ignored bits), then addr 7 N=1 with 0x55.
      cycle(32'h1234_5600, 1'b1, 8'h00, acc, r, b, w, dd);
      check("n0 wr_en", w, 8'h00);
      cycle(32'hE000_0001, 1'b1, 8'h00, acc, r, b, w, dd);
      check("n0 busy after", b, 1'b0);
      cycle(32'h0000_0055, 1'b1, 8'h00, acc, r, b, w, dd);
      check("addr7 wr_en", w, 8'h80);
      check("addr7 din", dd, 32'h55);

      // Reset after 2 of 5 payload words to addr 2, then addr 0 N=1.
      cycle(32'h4000_0005, 1'b1, 8'h00, acc, r, b, w, dd);
      cycle(32'hC0, 1'b1, 8'h00, acc, r, b, w, dd);
      cycle(32'hC1, 1'b1, 8'h00, acc, r, b, w, dd);
      apply_reset(32'hC2, 1'b1);
      cycle(32'h0000_0001, 1'b1, 8'h00, acc, r, b, w, dd);
      cycle(32'h0000_00E0, 1'b1, 8'h00, acc, r, b, w, dd);
      check("post-rst wr_en", w, 8'h01);
      check("post-rst din", dd, 32'hE0);

      // Five drops: the 2-bit counter pins at 3, the 16-bit one reaches 5.
      periph_enable = '0;
      for (int i = 0; i < 5; i++) begin
         cycle(32'h0000_0001, 1'b1, 8'h00, acc, r, b, w, dd);
         cycle(32'hFEED, 1'b1, 8'h00, acc, r, b, w, dd);
      end
      check("sat drop_s", drop_count_s, 2'd3);
      check("sat drop", drop_count, 16'd5);
      periph_enable = '1;

      // Maximum length packet to addr 6.
      cycle(32'hC000_00FF, 1'b1, 8'h00, acc, r, b, w, dd);
      for (int i = 0; i < 255; i++) begin
         cycle(32'h6000 + i, 1'b1, 8'h00, acc, r, b, w, dd);
      end
      check("maxlen last din", dd, 32'h6000 + 254);
      cycle(32'h0, 1'b0, 8'h00, acc, r, b, w, dd);
      check("maxlen idle", b, 1'b0);

      // Randomized traffic: gaps, backpressure, enable churn, odd header bits.
      for (int n = 0; n < 3000; n++) begin
         periph_enable = 8'($urandom() | $urandom());
         af            = 8'($urandom() & $urandom());
         if (pkt_left == 0) begin
            len = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(7, 40))
                                               : 8'($urandom_range(0, 6));
            dd  = {3'($urandom()), 21'($urandom()), len};
         end else begin
            dd  = $urandom();
         end
         cycle(dd, $urandom_range(0, 3) != 0, af, acc, r, b, w, dd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
